seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Four-digit multiplexed seven-segment display driver for the Spartan-6 board. Accepts a 14-bit binary value from counter logic and converts it to BCD with an iterative double-dabble engine. Time-multiplexes the four common-anode digits, and drives the shared active-low segment bus. It sits between counter/control blocks and the board's `digit`/`seg` pins, replacing per-design ad-hoc segment decode.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot. 1 kHz digit rate at 50 MHz. Minimum 2.
- `clk` in 1: 50 MHz system clock.
- `reset` in 1: synchronous, active-high reset. Clock is `clk`.
- `value` in 14: binary value to display, valid 0..9999.
- `load` in 1: one-cycle strobe; `value`/`dp_mask` sampled when `load`=1 and `busy`=0.
- `blank_lz` in 1: 1 = blank leading zeros (sampled at `load`).
- `dp_mask` in 4: decimal point enable per digit, bit i = digit i, 1 = lit.
- `busy` out 1: conversion in progress; `load` ignored while 1.
- `digit` out 4: active-low anode enables, exactly one bit low. Bit 0 = units (rightmost).
- `seg` out 8: active-low segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp.

## Operation
- Conversion FSM states:
  - IDLE: `busy`=0. On `load`, capture `value`, `blank_lz`, `dp_mask`, clear the 16-bit BCD register, go to SHIFT, cnt=0.
  - SHIFT: 14 cycles. Each cycle, add 3 to any BCD nibble ≥5, then shift {bcd,bin} left 1. Exit to COMMIT after cnt=13.
  - COMMIT: 1 cycle. Copy BCD nibbles and captured flags into display registers. Return to IDLE.
- Overflow: if captured `value` > 9999, COMMIT loads all four digits as dash (8'b11111101, dp forced off). Overflow uses the same latency as a normal conversion.
- Leading-zero blanking (`blank_lz`=1): digits 3..1 show 8'hFF while they and all higher digits are 0. Digit 0 is never blanked. Blanked digits still honour `dp_mask`.
- Segment decode, dp bit=1 (off):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101
  - 4=10011001, 5=01001001, 6=01000001, 7=00011111
  - 8=00000001, 9=00001001
- dp bit = ~dp_mask[i] for the active digit.
- Scanning:
  - Free-running divider counts 0..SCAN_DIV-1.
  - At terminal count the index advances 0→1→2→3→0.
  - `digit` = ~(1<<index).
  - Scanning is independent of the FSM and continues during conversion, showing the old display registers.
- `load` while `busy`=1 is dropped, not queued.

## Timing
- Reset values:
  - `busy`=0, FSM=IDLE, divider=0, index=0.
  - display regs = 0, flags = 0.
  - `digit`=4'b1110, `seg`=8'b00000011 (digit 0 shows "0").
- `digit` and `seg` are registered and change on the same edge, so there is no segment/anode skew.
- Load latency:
  - `load` sampled at edge N; `busy`=1 after N. SHIFT runs edges N+1..N+14.
  - COMMIT at edge N+15; `busy`=0 after N+15. Display regs update at N+15.
  - `seg` reflects the new value at edge N+16 if that digit is active.
- Earliest next accepted `load` is at edge N+16.
- Digit slot length is exactly SCAN_DIV cycles. The index increments at the edge where the divider wraps. `digit`/`seg` update on the following edge.
- Reset mid-conversion aborts. The display returns to reset values on the next edge, and the captured value is discarded.
- `load` and `reset` in the same cycle: reset wins.
- `dp_mask` and `blank_lz` take effect only at COMMIT, never asynchronously.

## Test plan
- Reset then idle, SCAN_DIV=4:
  - `digit` cycles 1110→1101→1011→0111→1110, changing every 4 clocks.
  - `seg`=00000011 on all four digits.
- `value`=1234, `load`, `blank_lz`=0:
  - `busy` high exactly 15 cycles.
  - After commit, digits 0..3 show 4,3,2,1 patterns (10011001, 00001101, 00100101, 10011111).
- `value`=7, `blank_lz`=1, `dp_mask`=4'b0010:
  - digit0=00011111; digit1=11111110 (blank, dp lit); digits 2,3=11111111.
- `value`=10000, `load`: all digits 11111101 after commit. Then `value`=9999: all digits 00001001.
- Second `load` (`value`=55) asserted at cycle N+5 of a conversion of 9: ignored, display shows 9 only.
- `reset` at cycle N+8 of a conversion of 4321: `busy`=0 and display "0" with digit=1110 on the next edge. No later update of 4321.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: iterative double-dabble binary-to-BCD
// conversion feeding display registers, plus a free-running anode scanner.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [7:0]  seg
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

  state_e            state_q, state_d;
  logic [13:0]       bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              blank_q, blank_d;
  logic [3:0]        dp_q, dp_d;
  logic [15:0]       disp_bcd_q, disp_bcd_d;
  logic              disp_ovf_q, disp_ovf_d;
  logic              disp_blank_q, disp_blank_d;
  logic [3:0]        disp_dp_q, disp_dp_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        digit_q, digit_d;
  logic [7:0]        seg_q, seg_d;

  logic [15:0]       bcd_adj;
  logic [15:0]       upper;
  logic [3:0]        cur_nib;
  logic              lead_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: nibbles >= 5 get +3 so the following shift carries into the next decade.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    blank_d      = blank_q;
    dp_d         = dp_q;
    disp_bcd_d   = disp_bcd_q;
    disp_ovf_d   = disp_ovf_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = 16'h0000;
          cnt_d   = 4'd0;
          ovf_d   = (value > 14'd9999);
          blank_d = blank_lz;
          dp_d    = dp_mask;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_bcd_d   = bcd_q;
        disp_ovf_d   = ovf_q;
        disp_blank_d = blank_q;
        disp_dp_d    = dp_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    idx_d      = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
    upper      = disp_bcd_q >> {idx_q, 2'b00};
    cur_nib    = upper[3:0];
    lead_blank = disp_blank_q && (idx_q != 2'd0) && (upper == 16'h0000);
    digit_d    = ~(4'b0001 << idx_q);
    if (disp_ovf_q) seg_d = 8'b11111101;
    else            seg_d = {lead_blank ? 7'b1111111 : decode(cur_nib), ~disp_dp_q[idx_q]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      blank_q      <= 1'b0;
      dp_q         <= '0;
      disp_bcd_q   <= '0;
      disp_ovf_q   <= 1'b0;
      disp_blank_q <= 1'b0;
      disp_dp_q    <= '0;
      div_q        <= '0;
      idx_q        <= '0;
      digit_q      <= 4'b1110;
      seg_q        <= 8'b00000011;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      blank_q      <= blank_d;
      dp_q         <= dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign digit = digit_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: loads push expected per-digit patterns, a monitor
// compares them against the scanned segment bus after each conversion completes.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        busy;
  logic [3:0]  digit;
  logic [7:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .busy(busy), .digit(digit), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'b0000001;  1: glyph = 7'b1001111;  2: glyph = 7'b0010010;
      3: glyph = 7'b0000110;  4: glyph = 7'b1001100;  5: glyph = 7'b0100100;
      6: glyph = 7'b0100000;  7: glyph = 7'b0001111;  8: glyph = 7'b0000000;
      default: glyph = 7'b0000100;
    endcase
  endfunction

  // Reference: pattern for each digit position, packed {d3,d2,d1,d0}.
  function automatic logic [31:0] model(input int v, input bit blz, input logic [3:0] dpm);
    logic [31:0] r;
    logic [6:0]  s;
    int p;
    p = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (v > 9999) r[8*i +: 8] = 8'b11111101;
      else begin
        s = (blz && i > 0 && v < p) ? 7'b1111111 : glyph((v / p) % 10);
        r[8*i +: 8] = {s, ~dpm[i]};
      end
      p = p * 10;
    end
    return r;
  endfunction

  // Monitor: each completed conversion is checked over one full scan rotation.
  initial begin
    logic        prev_busy;
    logic [31:0] e;
    int          idx;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prev_busy = 1'b0;
      else begin
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_commit: got commit, want none");
          end else begin
            e = exp_q.pop_front();
            repeat (4 * DIV) begin
              @(negedge clk);
              case (digit)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
              endcase
              if (idx < 0) check("digit_onehot", {28'h0, digit}, 32'h0000000e);
              else         check($sformatf("seg_digit%0d", idx), {24'h0, seg}, {24'h0, e[8*idx +: 8]});
            end
          end
        end
        prev_busy = busy;
      end
    end
  end

  task automatic do_load(input int v, input bit blz, input logic [3:0] dpm,
                         input int drop_at, input int rst_at);
    int k;
    @(posedge clk); #1;
    value = 14'(v); blank_lz = blz; dp_mask = dpm; load = 1'b1;
    if (rst_at == 0) exp_q.push_back(model(v, blz, dpm));
    @(posedge clk); #1;
    load = 1'b0;
    value = 14'($urandom_range(0, 16383)); blank_lz = 1'($urandom); dp_mask = 4'($urandom);
    check("busy_rise", {31'h0, busy}, 32'h1);
    k = 0;
    while (busy && k < 40) begin
      if (k + 1 == drop_at) begin value = 14'd55; load = 1'b1; end
      if (k + 1 == rst_at) reset = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      k++;
    end
    if (rst_at > 0) begin
      check("reset_abort_cycle", k, rst_at);
      check("reset_digit", {28'h0, digit}, 32'h0000000e);
      check("reset_seg", {24'h0, seg}, 32'h00000003);
      reset = 1'b0;
      repeat (4 * DIV + 8) begin
        @(posedge clk); #1;
        check("post_reset_seg", {24'h0, seg}, 32'h00000003);
        check("post_reset_busy", {31'h0, busy}, 32'h0);
      end
    end else begin
      check("busy_len", k, 15);
      repeat (4 * DIV + 4) @(posedge clk);
    end
  endtask

  initial begin
    int slot;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_digit", {28'h0, digit}, 32'h0000000e);
    check("rst_seg", {24'h0, seg}, 32'h00000003);
    reset = 1'b0;
    // Idle scan: after the k-th edge out of reset, slot (k-1)/DIV is active.
    for (int k = 1; k <= 5 * DIV; k++) begin
      @(posedge clk); #1;
      slot = ((k - 1) / DIV) % 4;
      check("idle_digit", {28'h0, digit}, {28'h0, ~(4'b0001 << slot)});
      check("idle_seg", {24'h0, seg}, 32'h00000003);
    end

    do_load(1234,  1'b0, 4'b0000, 0, 0);
    do_load(7,     1'b1, 4'b0010, 0, 0);
    do_load(10000, 1'b0, 4'b0000, 0, 0);
    do_load(9999,  1'b0, 4'b0000, 0, 0);
    do_load(0,     1'b1, 4'b1111, 0, 0);
    do_load(9,     1'b0, 4'b0000, 5, 0);
    do_load(4321,  1'b0, 4'b0000, 0, 8);
    for (int i = 0; i < 12; i++) begin
      do_load(($urandom_range(0, 7) == 0) ? int'($urandom_range(10000, 16383))
                                          : int'($urandom_range(0, 9999)),
              1'($urandom), 4'($urandom), 0, 0);
    end

    repeat (40) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
